// File: rtl/pow_unit_pkg.sv
// Shared arithmetic definitions: the control state encoding used by the
// power and root units, and the default operand width.
package pow_unit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQ   = 2'd1,
        ST_CU   = 2'd2
    } state_e;

endpackage

// File: rtl/pow_unit_shift_add_mul.sv
// One-bit-per-cycle unsigned shift-add multiplier. The caller owns the
// sequencing: clear_i restarts the product (and wins over step_i), and
// step_i adds the multiplicand shifted by the current bit position when
// that multiplier bit is set. next_acc_o is the accumulator value after
// the current step, so the caller can latch the finished product on the
// same edge that last_o marks as the final step.
module shift_add_mul #(
    parameter int A_W   = 16,
    parameter int B_W   = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    output logic [ACC_W-1:0] next_acc_o,
    output logic             last_o
);

    localparam int CTR_W = (B_W > 1) ? $clog2(B_W) : 1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] next_acc;
    logic [CTR_W-1:0] ctr_q, ctr_d;

    // Partial product for the current bit and the next accumulator state.
    always_comb begin
        addend   = b_i[ctr_q] ? (ACC_W'(a_i) << ctr_q) : '0;
        next_acc = acc_q + addend;
        acc_d    = acc_q;
        ctr_d    = ctr_q;
        if (clear_i) begin
            acc_d = '0;
            ctr_d = '0;
        end else if (step_i) begin
            acc_d = next_acc;
            ctr_d = ctr_q + 1'b1;
        end
    end

    assign next_acc_o = next_acc;
    assign last_o     = (ctr_q == CTR_W'(B_W - 1));

    // Accumulator and bit counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_q <= '0;
            ctr_q <= '0;
        end else begin
            acc_q <= acc_d;
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/pow_unit.sv
// Sequential power unit: computes x^2 then x^3 with one shared shift-add
// multiplier. Handshake: start_i is accepted only on an edge where the unit
// is idle (busy_o=0); the operand is captured on that edge, further start_i
// pulses while busy are dropped, and valid_o pulses for one cycle when
// sq_bo/y_bo update. start_i during the valid_o cycle is accepted.
module pow_unit
    import pow_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   x_bi,
    output logic               busy_o,
    output logic               valid_o,
    output logic [2*WIDTH-1:0] sq_bo,
    output logic [3*WIDTH-1:0] y_bo,
    output logic [1:0]         dbg_state_o
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [2*WIDTH-1:0] sq_q, sq_d;
    logic [2*WIDTH-1:0] sq_out_q, sq_out_d;
    logic [3*WIDTH-1:0] y_q, y_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;

    logic               mul_clear;
    logic               mul_step;
    logic [2*WIDTH-1:0] mul_a;
    logic [3*WIDTH-1:0] mul_next;
    logic               mul_last;

    // Control: next state, operand/square capture, result update.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        sq_d      = sq_q;
        sq_out_d  = sq_out_q;
        y_d       = y_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        mul_clear = 1'b0;
        mul_step  = 1'b0;
        mul_a     = {{WIDTH{1'b0}}, x_q};
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    x_d       = x_bi;
                    mul_clear = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_SQ;
                end
            end
            ST_SQ: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    sq_d      = mul_next[2*WIDTH-1:0];
                    mul_clear = 1'b1;
                    state_d   = ST_CU;
                end
            end
            ST_CU: begin
                mul_a    = sq_q;
                mul_step = 1'b1;
                if (mul_last) begin
                    sq_out_d  = sq_q;
                    y_d       = mul_next;
                    valid_d   = 1'b1;
                    busy_d    = 1'b0;
                    mul_clear = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand, square and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            sq_q     <= '0;
            sq_out_q <= '0;
            y_q      <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            sq_q     <= sq_d;
            sq_out_q <= sq_out_d;
            y_q      <= y_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    shift_add_mul #(
        .A_W   (2*WIDTH),
        .B_W   (WIDTH),
        .ACC_W (3*WIDTH)
    ) u_mul (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (mul_clear),
        .step_i     (mul_step),
        .a_i        (mul_a),
        .b_i        (x_q),
        .next_acc_o (mul_next),
        .last_o     (mul_last)
    );

    assign busy_o      = busy_q;
    assign valid_o     = valid_q;
    assign sq_bo       = sq_out_q;
    assign y_bo        = y_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pow_unit.sv
// Directed bench for pow_unit (WIDTH=8).
module tb_pow_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  x_in;
  logic        busy;
  logic        valid;
  logic [15:0] sq;
  logic [23:0] y;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_bad;

  pow_unit #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .start_i     (start),
    .x_bi        (x_in),
    .busy_o      (busy),
    .valid_o     (valid),
    .sq_bo       (sq),
    .y_bo        (y),
    .dbg_state_o (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after the accepting edge. Returns #1 after the edge that
  // raises valid (or after the cycle budget runs out).
  task automatic wait_done(input string tag, input logic [15:0] esq, input logic [23:0] ey);
    int n;
    logic busy_ok;
    n = 0;
    busy_ok = 1'b1;
    while (!valid && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_busy_held"}, {63'd0, busy_ok}, 64'd1);
    check({tag, "_latency"}, 64'(n), 64'd16);
    check({tag, "_sq"}, 64'(sq), 64'(esq));
    check({tag, "_y"}, 64'(y), 64'(ey));
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  // Called #1 after an edge with the unit idle.
  task automatic run_op(input string tag, input logic [7:0] x, input logic [15:0] esq,
                        input logic [23:0] ey);
    start = 1'b1;
    x_in  = x;
    @(posedge clk); #1;
    start = 1'b0;
    x_in  = 8'($urandom_range(0, 255));
    wait_done(tag, esq, ey);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 64'(valid), 64'd0);
  endtask

  // Count valid pulses over a window of cycles.
  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (valid) cnt++;
    end
  endtask

  initial begin
    int cnt;
    logic [7:0] perm [256];
    logic [7:0] tmp;
    int j;
    logic [15:0] msq;
    logic [23:0] my;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    x_in  = 8'd0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_sq", 64'(sq), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic vectors
    run_op("x3", 8'd3, 16'd9, 24'd27);
    run_op("x0", 8'd0, 16'd0, 24'd0);
    run_op("x255", 8'd255, 16'hFE01, 24'hFD02FF);
    run_op("x1", 8'd1, 16'd1, 24'd1);
    run_op("x128", 8'd128, 16'h4000, 24'h200000);

    // start ignored while busy; operand held
    start = 1'b1;
    x_in  = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) begin start = 1'b1; x_in = 8'd7; end
      else start = 1'b0;
      if (k == 10) x_in = 8'd200;
      @(posedge clk); #1;
      check("ign_no_early_valid", 64'(valid), 64'd0);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("ign_valid", 64'(valid), 64'd1);
    check("ign_sq", 64'(sq), 64'd25);
    check("ign_y", 64'(y), 64'd125);
    count_valid(24, cnt);
    check("ign_single_valid", 64'(cnt), 64'd0);
    check("ign_idle", 64'(busy), 64'd0);

    // back-to-back: new start during the valid cycle
    start = 1'b1;
    x_in  = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b_a", 16'd4, 24'd8);
    start = 1'b1;
    x_in  = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy_after_accept", 64'(busy), 64'd1);
    wait_done("b2b_b", 16'd100, 24'd1000);
    @(posedge clk); #1;

    // reset mid-SQ, asynchronously between edges
    start = 1'b1;
    x_in  = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rsq_busy", 64'(busy), 64'd0);
    check("rsq_sq", 64'(sq), 64'd0);
    check("rsq_y", 64'(y), 64'd0);
    check("rsq_valid", 64'(valid), 64'd0);
    #2;
    rst_n = 1'b1;
    count_valid(20, cnt);
    check("rsq_no_valid", 64'(cnt), 64'd0);

    // reset mid-CU
    run_op("pre_rcu", 8'd4, 16'd16, 24'd64);
    start = 1'b1;
    x_in  = 8'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rcu_busy", 64'(busy), 64'd0);
    check("rcu_sq", 64'(sq), 64'd0);
    check("rcu_y", 64'(y), 64'd0);
    check("rcu_state", 64'(dbg_state), 64'd0);
    #2;
    rst_n = 1'b1;
    count_valid(20, cnt);
    check("rcu_no_valid", 64'(cnt), 64'd0);
    run_op("post_rst", 8'd6, 16'd36, 24'd216);

    // sweep over every operand in shuffled order
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      msq = 16'(perm[i]) * 16'(perm[i]);
      my  = 24'(msq) * 24'(perm[i]);
      run_op("sweep", perm[i], msq, my);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
